// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;
  localparam int DEF_WIDTH = 8;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ADD  = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake plus operand and result buses of the serial adder.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (output start, a, b, c_in, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
endinterface

// File: rtl/serial_adder_fa.sv
// 1-bit full adder, purely combinational.
module FA (
  output logic s,
  output logic Carry_out,
  input  logic x,
  input  logic y,
  input  logic Carry_in
);
  assign s         = x ^ y ^ Carry_in;
  assign Carry_out = (x & y) | (Carry_in & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, WIDTH cycles per add.
// busy/done decode straight from the state register; start only honoured in IDLE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ss;
  logic             r_cr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_ss_next;
  logic             w_unused_ss0;

  FA u_fa (
    .s         (w_s),
    .Carry_out (w_co),
    .x         (r_sa[0]),
    .y         (r_sb[0]),
    .Carry_in  (r_cr)
  );

  // New sum bit enters at the MSB so after WIDTH steps the LSB has reached bit 0.
  generate
    if (WIDTH == 1) begin : g_ss1
      assign w_ss_next = w_s;
    end else begin : g_ssn
      assign w_ss_next = {w_s, r_ss[WIDTH-1:1]};
    end
  endgenerate

  assign w_last       = (r_cnt == CW'(WIDTH - 1));
  assign w_unused_ss0 = r_ss[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_ss    <= '0;
      r_cr    <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_cr    <= bus.c_in;
            r_cnt   <= '0;
            r_ss    <= '0;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_ss  <= w_ss_next;
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_cr  <= w_co;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum   <= w_ss_next;
            r_c_out <= w_co;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (r_state == ADD);
  assign bus.done  = (r_state == DONE);
  assign bus.sum   = r_sum;
  assign bus.c_out = r_c_out;
endmodule
